// File: rtl/load_store_unit_pkg.sv
// Shared types and widths for the memory-stage load/store unit.
package load_store_unit_pkg;

  localparam int XLEN   = 64;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Memory-stage LSU: passes ALU results to writeback and runs half-word
// accesses as single pipelined Wishbone cycles on a 16-bit master port.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              we_i,
  input  logic              nomem_i,
  input  logic              hword_i,
  input  logic [XLEN-1:0]   dat_i,
  output logic              busy_o,
  output logic              rwe_o,
  output logic [XLEN-1:0]   dat_o,
  output logic [XLEN-1:0]   wbmadr_o,
  output logic [BUS_DW-1:0] wbmdat_o,
  output logic              wbmwe_o,
  output logic              wbmstb_o,
  input  logic              wbmack_i
);

  lsu_state_e        state_reg, state_next;
  logic              busy_reg, busy_next;
  logic              rwe_reg, rwe_next;
  logic [XLEN-1:0]   dat_reg, dat_next;
  logic [XLEN-1:0]   adr_reg, adr_next;
  logic [BUS_DW-1:0] wdat_reg, wdat_next;
  logic              we_reg, we_next;
  logic              stb_reg, stb_next;

  // Only the low half-word of the store data ever reaches the bus.
  logic unused_dat_bits;
  assign unused_dat_bits = ^dat_i[XLEN-1:BUS_DW];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      rwe_reg   <= 1'b0;
      dat_reg   <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      we_reg    <= 1'b0;
      stb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      rwe_reg   <= rwe_next;
      dat_reg   <= dat_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      we_reg    <= we_next;
      stb_reg   <= stb_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    rwe_next   = rwe_reg;
    dat_next   = dat_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    we_next    = we_reg;
    stb_next   = stb_reg;

    case (state_reg)
      ST_IDLE: begin
        stb_next = 1'b0;
        if (nomem_i) begin
          dat_next = addr_i;
          rwe_next = 1'b1;
        end else begin
          rwe_next = 1'b0;
          if (hword_i) begin
            adr_next   = addr_i;
            wdat_next  = dat_i[BUS_DW-1:0];
            we_next    = we_i;
            stb_next   = 1'b1;
            busy_next  = 1'b1;
            state_next = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stb_next = 1'b0;
        rwe_next = 1'b0;
        // A fast slave may acknowledge in the strobe cycle itself.
        if (wbmack_i) begin
          busy_next  = 1'b0;
          we_next    = 1'b0;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        stb_next = 1'b0;
        rwe_next = 1'b0;
        if (wbmack_i) begin
          busy_next  = 1'b0;
          we_next    = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        busy_next  = 1'b0;
        stb_next   = 1'b0;
        rwe_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_o   = busy_reg;
  assign rwe_o    = rwe_reg;
  assign dat_o    = dat_reg;
  assign wbmadr_o = adr_reg;
  assign wbmdat_o = wdat_reg;
  assign wbmwe_o  = we_reg;
  assign wbmstb_o = stb_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] addr_i;
  logic        we_i;
  logic        nomem_i;
  logic        hword_i;
  logic [63:0] dat_i;
  logic        busy_o;
  logic        rwe_o;
  logic [63:0] dat_o;
  logic [63:0] wbmadr_o;
  logic [15:0] wbmdat_o;
  logic        wbmwe_o;
  logic        wbmstb_o;
  logic        wbmack_i;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .nomem_i (nomem_i),
    .hword_i (hword_i),
    .dat_i   (dat_i),
    .busy_o  (busy_o),
    .rwe_o   (rwe_o),
    .dat_o   (dat_o),
    .wbmadr_o(wbmadr_o),
    .wbmdat_o(wbmdat_o),
    .wbmwe_o (wbmwe_o),
    .wbmstb_o(wbmstb_o),
    .wbmack_i(wbmack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".rwe"},  64'(rwe_o),  64'd0);
    check({tag, ".dat"},  dat_o,       64'd0);
    check({tag, ".adr"},  wbmadr_o,    64'd0);
    check({tag, ".wdat"}, 64'(wbmdat_o), 64'd0);
    check({tag, ".we"},   64'(wbmwe_o),  64'd0);
    check({tag, ".stb"},  64'(wbmstb_o), 64'd0);
  endtask

  initial begin
    reset_i  = 1'b1;
    addr_i   = '0;
    we_i     = 1'b0;
    nomem_i  = 1'b0;
    hword_i  = 1'b0;
    dat_i    = '0;
    wbmack_i = 1'b0;

    // Reset held across an edge, then released into an idle cycle
    tick();
    check_all_zero("rst_held");
    reset_i = 1'b0;
    tick();
    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.rwe",  64'(rwe_o),  64'd0);
    check("rst.stb",  64'(wbmstb_o), 64'd0);
    check("rst.dat",  dat_o, 64'd0);
    $display("step reset: busy=%0b rwe=%0b dat=%h", busy_o, rwe_o, dat_o);

    // Passthrough, load-type
    nomem_i = 1'b1; we_i = 1'b0;
    addr_i = 64'h1122334455667788; dat_i = 64'h7766554433221100;
    tick();
    check("pass_ld.dat",  dat_o, 64'h1122334455667788);
    check("pass_ld.rwe",  64'(rwe_o),  64'd1);
    check("pass_ld.busy", 64'(busy_o), 64'd0);
    $display("step pass_ld: dat=%h rwe=%0b", dat_o, rwe_o);

    // Passthrough with we_i=1 must not start a bus cycle
    we_i = 1'b1;
    tick();
    check("pass_st.dat", dat_o, 64'h1122334455667788);
    check("pass_st.rwe", 64'(rwe_o), 64'd1);
    check("pass_st.stb", 64'(wbmstb_o), 64'd0);
    $display("step pass_st: dat=%h rwe=%0b stb=%0b", dat_o, rwe_o, wbmstb_o);

    // Back-to-back passthrough with a new value
    addr_i = 64'hA5A5_0000_FFFF_5A5A;
    tick();
    check("pass_b2b.dat", dat_o, 64'hA5A5_0000_FFFF_5A5A);
    check("pass_b2b.rwe", 64'(rwe_o), 64'd1);
    $display("step pass_b2b: dat=%h", dat_o);

    // Idle: writeback drops, data holds
    nomem_i = 1'b0; hword_i = 1'b0; addr_i = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("idle.rwe", 64'(rwe_o), 64'd0);
    check("idle.dat", dat_o, 64'hA5A5_0000_FFFF_5A5A);
    check("idle.stb", 64'(wbmstb_o), 64'd0);
    $display("step idle: rwe=%0b dat=%h", rwe_o, dat_o);

    // Half-word store with a waiting slave
    hword_i = 1'b1; we_i = 1'b1;
    addr_i = 64'h1122334455667788; dat_i = 64'h7766554433221100;
    tick();
    check("st_e1.busy", 64'(busy_o), 64'd1);
    check("st_e1.adr",  wbmadr_o, 64'h1122334455667788);
    check("st_e1.wdat", 64'(wbmdat_o), 64'h1100);
    check("st_e1.we",   64'(wbmwe_o), 64'd1);
    check("st_e1.stb",  64'(wbmstb_o), 64'd1);
    check("st_e1.rwe",  64'(rwe_o), 64'd0);
    $display("step st_e1: busy=%0b adr=%h wdat=%h we=%0b stb=%0b", busy_o, wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o);
    // Inputs while busy are ignored, including a nomem request
    hword_i = 1'b0; nomem_i = 1'b1; addr_i = 64'h0BAD_0BAD_0BAD_0BAD; dat_i = 64'hFFFF;
    tick();
    check("st_e2.busy", 64'(busy_o), 64'd1);
    check("st_e2.stb",  64'(wbmstb_o), 64'd0);
    check("st_e2.rwe",  64'(rwe_o), 64'd0);
    check("st_e2.dat",  dat_o, 64'hA5A5_0000_FFFF_5A5A);
    check("st_e2.adr",  wbmadr_o, 64'h1122334455667788);
    check("st_e2.wdat", 64'(wbmdat_o), 64'h1100);
    $display("step st_e2: busy=%0b stb=%0b adr=%h", busy_o, wbmstb_o, wbmadr_o);
    tick();
    check("st_wait.busy", 64'(busy_o), 64'd1);
    check("st_wait.stb",  64'(wbmstb_o), 64'd0);
    check("st_wait.we",   64'(wbmwe_o), 64'd1);
    $display("step st_wait: busy=%0b", busy_o);
    nomem_i = 1'b0; wbmack_i = 1'b1;
    tick();
    wbmack_i = 1'b0;
    check("st_e3.busy", 64'(busy_o), 64'd0);
    check("st_e3.rwe",  64'(rwe_o), 64'd0);
    check("st_e3.we",   64'(wbmwe_o), 64'd0);
    check("st_e3.adr",  wbmadr_o, 64'h1122334455667788);
    check("st_e3.dat",  dat_o, 64'hA5A5_0000_FFFF_5A5A);
    $display("step st_e3: busy=%0b rwe=%0b we=%0b", busy_o, rwe_o, wbmwe_o);

    // Half-word read acknowledged in the strobe cycle
    hword_i = 1'b1; we_i = 1'b0;
    addr_i = 64'h0000_0000_0000_1234; dat_i = 64'h1111_2222_3333_BEEF;
    tick();
    check("rd_e1.busy", 64'(busy_o), 64'd1);
    check("rd_e1.we",   64'(wbmwe_o), 64'd0);
    check("rd_e1.stb",  64'(wbmstb_o), 64'd1);
    check("rd_e1.adr",  wbmadr_o, 64'h0000_0000_0000_1234);
    check("rd_e1.wdat", 64'(wbmdat_o), 64'hBEEF);
    $display("step rd_e1: busy=%0b we=%0b adr=%h", busy_o, wbmwe_o, wbmadr_o);
    hword_i = 1'b0; wbmack_i = 1'b1;
    tick();
    wbmack_i = 1'b0;
    check("rd_ack.busy", 64'(busy_o), 64'd0);
    check("rd_ack.stb",  64'(wbmstb_o), 64'd0);
    check("rd_ack.rwe",  64'(rwe_o), 64'd0);
    check("rd_ack.dat",  dat_o, 64'hA5A5_0000_FFFF_5A5A);
    $display("step rd_ack: busy=%0b rwe=%0b dat=%h", busy_o, rwe_o, dat_o);

    // nomem wins over hword
    nomem_i = 1'b1; hword_i = 1'b1; we_i = 1'b1; addr_i = 64'hCAFE_F00D_1234_5678;
    tick();
    check("prio.rwe",  64'(rwe_o), 64'd1);
    check("prio.busy", 64'(busy_o), 64'd0);
    check("prio.stb",  64'(wbmstb_o), 64'd0);
    check("prio.dat",  dat_o, 64'hCAFE_F00D_1234_5678);
    $display("step prio: rwe=%0b busy=%0b dat=%h", rwe_o, busy_o, dat_o);

    // Ack in idle is ignored
    nomem_i = 1'b0; hword_i = 1'b0; wbmack_i = 1'b1;
    tick();
    wbmack_i = 1'b0;
    check("idle_ack.busy", 64'(busy_o), 64'd0);
    check("idle_ack.stb",  64'(wbmstb_o), 64'd0);
    check("idle_ack.rwe",  64'(rwe_o), 64'd0);
    $display("step idle_ack: busy=%0b stb=%0b", busy_o, wbmstb_o);

    // Reset mid-WAIT aborts immediately
    hword_i = 1'b1; we_i = 1'b1; addr_i = 64'h0000_0000_0000_00F0; dat_i = 64'h0000_0000_0000_ABCD;
    tick();
    hword_i = 1'b0;
    tick();
    check("wait_pre.busy", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    #1;
    check_all_zero("rst_async");
    $display("step rst_async: busy=%0b adr=%h", busy_o, wbmadr_o);
    tick();
    reset_i = 1'b0;
    tick();
    check("post_rst.busy", 64'(busy_o), 64'd0);
    check("post_rst.stb",  64'(wbmstb_o), 64'd0);
    $display("step post_rst: busy=%0b stb=%0b", busy_o, wbmstb_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit for the 64-bit KCP53K-style pipeline.
- Non-memory instructions pass the ALU result (addr_i) straight to register writeback.
- Half-word stores (and reads) run as a single Wishbone transaction on a 16-bit master port. The pipeline stalls via busy_o until the slave acknowledges.

Parameters:
- none

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- addr_i  in  64  effective address, or ALU result when nomem_i=1
- we_i  in  1  1 = store, 0 = load (memory ops only)
- nomem_i  in  1  instruction does not access memory; pass addr_i through
- hword_i  in  1  half-word memory request strobe
- dat_i  in  64  store data; only bits [15:0] are used
- busy_o  out  1  LSU is mid-transaction; upstream must hold/stall
- rwe_o  out  1  register-file write enable for writeback
- dat_o  out  64  writeback data
- wbmadr_o  out  64  Wishbone address
- wbmdat_o  out  16  Wishbone write data
- wbmwe_o  out  1  Wishbone write enable
- wbmstb_o  out  1  Wishbone strobe (pipelined mode, one-cycle pulse)
- wbmack_i  in  1  Wishbone acknowledge

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_i=1) sets every output to 0 and the FSM to IDLE.
- FSM states:
  - IDLE: accepts requests.
  - REQ: strobe cycle.
  - WAIT: awaiting ack.
- IDLE acceptance priority: nomem_i > hword_i > nothing.
- IDLE, nomem_i=1 (any we_i, hword_i):
  - next edge: dat_o<=addr_i, rwe_o<=1, busy_o stays 0.
  - back-to-back nomem cycles each produce one writeback.
- IDLE, nomem_i=0, hword_i=0:
  - next edge: rwe_o<=0; dat_o holds; no bus activity.
- IDLE, nomem_i=0, hword_i=1:
  - next edge: wbmadr_o<=addr_i, wbmdat_o<=dat_i[15:0], wbmwe_o<=we_i, wbmstb_o<=1, busy_o<=1, rwe_o<=0; go to REQ.
- REQ (exactly one cycle):
  - next edge: wbmstb_o<=0.
  - If wbmack_i=1 this cycle, go to IDLE with busy_o<=0; else go to WAIT with busy_o=1.
- WAIT:
  - stay while wbmack_i=0, holding busy_o=1, wbmstb_o=0, rwe_o=0.
  - On the edge where wbmack_i=1: busy_o<=0, wbmwe_o<=0, go to IDLE.
- Stores complete with rwe_o=0.
- Reads (we_i=0): run the same bus cycle with wbmwe_o=0.
  - No read-data port exists in this revision, so reads complete with rwe_o=0 and dat_o unchanged.
- While busy (REQ/WAIT): addr_i, dat_i, we_i, nomem_i and hword_i are ignored. wbmadr_o/wbmdat_o hold their values through the transaction and after it.
- wbmack_i in IDLE is ignored.
- reset_i asserted mid-transaction: abort immediately, all outputs 0, IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/WAIT, 2 bits), XLEN=64, bus data width 16.
- Single module, no sub-modules. An optional separate wishbone_master_fsm is acceptable but not required.

Test Plan:
- Reset: assert reset_i for one edge, then release -> busy_o=0, rwe_o=0, wbmstb_o=0, dat_o=0.
- Passthrough load-type: nomem_i=1, we_i=0, addr_i=64'h1122334455667788, dat_i=64'h7766554433221100 -> after one edge dat_o=64'h1122334455667788, rwe_o=1, busy_o=0.
- Passthrough with we_i=1: same values -> dat_o=64'h1122334455667788, rwe_o=1, no strobe.
- Idle: nomem_i=0, hword_i=0 -> after one edge rwe_o=0.
- Half-word store: hword_i=1 for one cycle, we_i=1, same addr/data.
  - Edge 1: busy_o=1, wbmadr_o=64'h1122334455667788, wbmdat_o=16'h1100, wbmwe_o=1, wbmstb_o=1, rwe_o=0.
  - Edge 2: busy_o=1, wbmstb_o=0, rwe_o=0.
  - Raise wbmack_i, then edge 3: busy_o=0, rwe_o=0, wbmwe_o=0.
- Ack during REQ, and reset mid-WAIT:
  - Ack in the strobe cycle -> busy_o=0 on the next edge.
  - reset_i pulsed in WAIT -> all outputs 0 immediately.
